// File: rtl/idli_sqi_fetch_m.sv
// Instruction fetch front end for a quad-SPI (SQI) SRAM.
// Issues a sequential READ at the fetch PC and streams the returned
// instruction nibbles (MSB first) to the decoder, one per cycle.
module idli_sqi_fetch_m (
  input  logic        i_fet_gck,
  input  logic        i_fet_rst_n,
  input  logic        i_fet_redirect,
  input  logic [15:0] i_fet_redirect_pc,
  input  logic [3:0]  i_fet_sqi_sio,
  output logic [3:0]  o_fet_sqi_sio,
  output logic        o_fet_sqi_oe,
  output logic        o_fet_sqi_cs_n,
  output logic [3:0]  o_fet_enc,
  output logic        o_fet_enc_vld,
  output logic [15:0] o_fet_pc
);

  typedef enum logic [2:0] {
    ST_RESTART,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  step, step_nxt;   // cycle index within CMD/ADDR/DUMMY
  logic [1:0]  nib, nib_nxt;     // nibble position within the current instruction
  logic [15:0] pc, pc_nxt;
  logic [23:0] addr;

  // Word address to byte address; upper bits are always zero.
  assign addr     = {7'b0, pc, 1'b0};
  assign o_fet_pc = pc;

  // State, counters and fetch PC register.
  always_ff @(posedge i_fet_gck or negedge i_fet_rst_n) begin
    if (!i_fet_rst_n) begin
      state <= ST_RESTART;
      step  <= '0;
      nib   <= '0;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      nib   <= nib_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next-state sequencing; a redirect overrides everything.
  always_comb begin
    state_nxt = state;
    step_nxt  = step + 3'd1;
    nib_nxt   = nib;
    pc_nxt    = pc;
    case (state)
      ST_RESTART: begin
        state_nxt = ST_CMD;
        step_nxt  = '0;
      end
      ST_CMD: begin
        if (step == 3'd1) begin
          state_nxt = ST_ADDR;
          step_nxt  = '0;
        end
      end
      ST_ADDR: begin
        if (step == 3'd5) begin
          state_nxt = ST_DUMMY;
          step_nxt  = '0;
        end
      end
      ST_DUMMY: begin
        if (step == 3'd1) begin
          state_nxt = ST_DATA;
          step_nxt  = '0;
        end
      end
      ST_DATA: begin
        step_nxt = '0;
        nib_nxt  = nib + 2'd1;
        if (nib == 2'd3) begin
          pc_nxt = pc + 16'd1;
        end
      end
      default: begin
        state_nxt = ST_RESTART;
        step_nxt  = '0;
      end
    endcase
    if (i_fet_redirect) begin
      state_nxt = ST_RESTART;
      step_nxt  = '0;
      nib_nxt   = '0;
      pc_nxt    = i_fet_redirect_pc;
    end
  end

  // Pad and decoder outputs decoded from the registered state.
  always_comb begin
    o_fet_sqi_cs_n = 1'b0;
    o_fet_sqi_oe   = 1'b0;
    o_fet_sqi_sio  = '0;
    o_fet_enc_vld  = 1'b0;
    o_fet_enc      = '0;
    case (state)
      ST_RESTART: begin
        o_fet_sqi_cs_n = 1'b1;
      end
      ST_CMD: begin
        o_fet_sqi_oe  = 1'b1;
        o_fet_sqi_sio = step[0] ? 4'h3 : 4'h0;
      end
      ST_ADDR: begin
        o_fet_sqi_oe = 1'b1;
        case (step)
          3'd0:    o_fet_sqi_sio = addr[23:20];
          3'd1:    o_fet_sqi_sio = addr[19:16];
          3'd2:    o_fet_sqi_sio = addr[15:12];
          3'd3:    o_fet_sqi_sio = addr[11:8];
          3'd4:    o_fet_sqi_sio = addr[7:4];
          3'd5:    o_fet_sqi_sio = addr[3:0];
          default: o_fet_sqi_sio = '0;
        endcase
      end
      ST_DUMMY: begin
        o_fet_sqi_oe = 1'b0;
      end
      ST_DATA: begin
        // The nibble arriving in a redirect cycle belongs to the old stream.
        o_fet_enc_vld = !i_fet_redirect;
        o_fet_enc     = i_fet_redirect ? 4'h0 : i_fet_sqi_sio;
      end
      default: begin
        o_fet_sqi_cs_n = 1'b1;
      end
    endcase
  end

endmodule
